// File: rtl/handshake_event_tx_if.sv
// Local-side and crossing signals of the four-phase event sender.
// The master view belongs to the sender; the slave view belongs to the environment.
interface handshake_event_tx_if #(
    parameter int WIDTH = 8
);
    logic             send;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             req_out;
    logic [WIDTH-1:0] data_out;
    logic             ack_in;
    logic             done;
    logic             overflow;
    logic             timeout_err;

    modport master (
        input  send, data_in, ack_in,
        output ready, req_out, data_out, done, overflow, timeout_err
    );

    modport slave (
        output send, data_in, ack_in,
        input  ready, req_out, data_out, done, overflow, timeout_err
    );
endinterface

// File: rtl/handshake_event_tx.sv
// Four-phase req/ack sender. It accepts local event strobes into a one-entry
// pending buffer and holds each word stable until the remote side has acknowledged it.
module handshake_event_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 clr,
    handshake_event_tx_if.master bus
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic                   ack_s;
    logic                   pend_v_reg;
    logic [WIDTH-1:0]       pend_d_reg;
    logic [WIDTH-1:0]       data_reg;
    logic                   req_reg;
    logic                   done_reg;
    logic                   overflow_reg;
    logic                   timeout_reg;
    logic                   aborted_reg;
    logic [TW-1:0]          timer_reg;
    logic [TW-1:0]          timer_next;

    // ack_in is asynchronous; only the last stage of this chain is used.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ack_sync_reg <= '0;
        end else begin
            ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], bus.ack_in};
        end
    end

    assign ack_s      = ack_sync_reg[SYNC_STAGES-1];
    assign timer_next = timer_reg + 1'b1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg    <= IDLE;
            pend_v_reg   <= 1'b0;
            pend_d_reg   <= '0;
            data_reg     <= '0;
            req_reg      <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            aborted_reg  <= 1'b0;
            timer_reg    <= '0;
        end else begin
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (pend_v_reg) begin
                        data_reg    <= pend_d_reg;
                        req_reg     <= 1'b1;
                        timer_reg   <= '0;
                        aborted_reg <= 1'b0;
                        state_reg   <= REQ_HI;
                        // A strobe arriving now refills the slot being vacated.
                        if (bus.send) begin
                            pend_d_reg <= bus.data_in;
                        end else begin
                            pend_v_reg <= 1'b0;
                        end
                    end else if (bus.send) begin
                        data_reg    <= bus.data_in;
                        req_reg     <= 1'b1;
                        timer_reg   <= '0;
                        aborted_reg <= 1'b0;
                        state_reg   <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_reg   <= 1'b0;
                        state_reg <= REQ_LO;
                    end else if ((TIMEOUT != 0) && (timer_next == TIMEOUT_L)) begin
                        req_reg     <= 1'b0;
                        timeout_reg <= 1'b1;
                        aborted_reg <= 1'b1;
                        state_reg   <= REQ_LO;
                    end else if (timer_reg != '1) begin
                        timer_reg <= timer_next;
                    end
                end
                REQ_LO: begin
                    // Waiting for ack_s low here is what keeps req from rising into a stale ack.
                    if (!ack_s) begin
                        done_reg  <= !aborted_reg;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase

            if ((state_reg != IDLE) && bus.send) begin
                if (pend_v_reg) begin
                    overflow_reg <= 1'b1;
                end else begin
                    pend_v_reg <= 1'b1;
                    pend_d_reg <= bus.data_in;
                end
            end
        end
    end

    assign bus.ready       = !pend_v_reg;
    assign bus.req_out     = req_reg;
    assign bus.data_out    = data_reg;
    assign bus.done        = done_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.timeout_err = timeout_reg;
endmodule

// File: tb/tb_handshake_event_tx.sv
// Directed and randomized checks of the event sender against a simple far-side receiver
// and an event-log model, where each accepted word is expected to be delivered once, in order.
module tb_handshake_event_tx;
    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 10;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    handshake_event_tx_if #(.WIDTH(WIDTH)) bus ();

    handshake_event_tx #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.master)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         done_cnt, ovf_cnt, to_cnt;
    logic [7:0] launched[$];
    logic [7:0] rx_cap[$];
    int         launch_cyc[$];
    int         done_cyc[$];
    logic       prev_req = 1'b0;
    logic [7:0] held = '0;

    int ack_dly = 3;
    int rel_dly = 3;
    bit rx_en   = 1'b1;
    int rx_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] d);
        bus.send    = 1'b1;
        bus.data_in = d;
        tick();
        bus.send    = 1'b0;
    endtask

    task automatic clear_logs();
        done_cnt = 0; ovf_cnt = 0; to_cnt = 0;
        launched.delete(); rx_cap.delete();
        launch_cyc.delete(); done_cyc.delete();
    endtask

    task automatic wait_quiet();
        int q = 0;
        int n = 0;
        while (q < 6 && n < 300) begin
            tick();
            n++;
            if (!bus.req_out && !bus.ack_in && bus.ready && !bus.send) q++;
            else q = 0;
        end
        check("quiet", 32'(q >= 6), 32'd1);
    endtask

    task automatic cmp_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    // Event log: launches (req rising), pulses, and data stability while req is high.
    always @(negedge clk) begin
        cyc++;
        if (clr) begin
            prev_req = 1'b0;
        end else begin
            if (bus.req_out && !prev_req) begin
                launched.push_back(bus.data_out);
                launch_cyc.push_back(cyc);
                held = bus.data_out;
            end else if (bus.req_out) begin
                check("data_stable", 32'(bus.data_out), 32'(held));
            end
            if (bus.done) begin done_cnt++; done_cyc.push_back(cyc); end
            if (bus.overflow) ovf_cnt++;
            if (bus.timeout_err) to_cnt++;
            prev_req = bus.req_out;
        end
    end

    // Far-side receiver: acks ack_dly cycles after req rises, releases rel_dly after it falls.
    always @(negedge clk) begin
        if (clr) begin
            bus.ack_in = 1'b0;
            rx_cnt     = 0;
        end else if (!bus.ack_in) begin
            if (bus.req_out && rx_en) begin
                rx_cnt++;
                if (rx_cnt >= ack_dly) begin
                    bus.ack_in = 1'b1;
                    rx_cap.push_back(bus.data_out);
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt = 0;
            end
        end else if (!bus.req_out) begin
            rx_cnt++;
            if (rx_cnt >= rel_dly) begin
                bus.ack_in = 1'b0;
                rx_cnt     = 0;
            end
        end
    end

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] words[4];
        int         k;
        int         n;

        bus.send    = 1'b0;
        bus.data_in = '0;
        clear_logs();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", 32'(bus.req_out), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_tmo", 32'(bus.timeout_err), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        clr = 1'b0;
        tick();

        // Single transfer
        clear_logs();
        send_word(8'hA5);
        check("t1_req_rise", 32'(bus.req_out), 32'd1);
        check("t1_data", 32'(bus.data_out), 32'hA5);
        wait_quiet();
        exp_q = '{8'hA5};
        cmp_q("t1_launch", launched, exp_q);
        cmp_q("t1_rx", rx_cap, exp_q);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_data_held", 32'(bus.data_out), 32'hA5);

        // Back-to-back: second word waits in the buffer
        clear_logs();
        send_word(8'h11);
        send_word(8'h22);
        check("t2_ready_low", 32'(bus.ready), 32'd0);
        wait_quiet();
        exp_q = '{8'h11, 8'h22};
        cmp_q("t2_launch", launched, exp_q);
        check("t2_done", 32'(done_cnt), 32'd2);
        if (launch_cyc.size() == 2 && done_cyc.size() == 2)
            check("t2_gap", 32'(launch_cyc[1] - done_cyc[0]), 32'd1);
        else
            check("t2_log_size", 32'(launch_cyc.size() + done_cyc.size()), 32'd4);

        // Overflow on the third consecutive strobe
        clear_logs();
        send_word(8'h01);
        check("t3_ovf_1", 32'(bus.overflow), 32'd0);
        send_word(8'h02);
        check("t3_ovf_2", 32'(bus.overflow), 32'd0);
        send_word(8'h03);
        check("t3_ovf_3", 32'(bus.overflow), 32'd1);
        wait_quiet();
        exp_q = '{8'h01, 8'h02};
        cmp_q("t3_launch", launched, exp_q);
        check("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
        check("t3_done", 32'(done_cnt), 32'd2);

        // New strobe in the IDLE cycle where the pending word launches
        clear_logs();
        send_word(8'h55);
        send_word(8'h33);
        n = 0;
        while (!bus.done && n < 100) begin tick(); n++; end
        check("t4_done_seen", 32'(bus.done), 32'd1);
        send_word(8'h44);
        wait_quiet();
        exp_q = '{8'h55, 8'h33, 8'h44};
        cmp_q("t4_launch", launched, exp_q);
        cmp_q("t4_rx", rx_cap, exp_q);
        check("t4_ovf", 32'(ovf_cnt), 32'd0);
        check("t4_done", 32'(done_cnt), 32'd3);

        // Timeout with no acknowledge
        clear_logs();
        rx_en = 1'b0;
        send_word(8'h77);
        n = 1;
        while (bus.req_out && n < 50) begin
            tick();
            if (bus.req_out) n++;
        end
        check("t5_hi_len", 32'(n), 32'(TMO));
        check("t5_tmo_pulse", 32'(bus.timeout_err), 32'd1);
        wait_quiet();
        check("t5_no_done", 32'(done_cnt), 32'd0);
        check("t5_tmo_cnt", 32'(to_cnt), 32'd1);
        rx_en = 1'b1;
        clear_logs();
        send_word(8'h78);
        wait_quiet();
        check("t5_after_done", 32'(done_cnt), 32'd1);
        exp_q = '{8'h78};
        cmp_q("t5_after_rx", rx_cap, exp_q);
        check("t5_after_tmo", 32'(to_cnt), 32'd0);

        // Asynchronous reset while in REQ_HI with a word pending
        clear_logs();
        send_word(8'h66);
        send_word(8'h67);
        #2 clr = 1'b1;
        #1;
        check("t6_req_clr", 32'(bus.req_out), 32'd0);
        check("t6_ready_clr", 32'(bus.ready), 32'd1);
        check("t6_done_clr", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        wait_quiet();
        check("t6_no_done", 32'(done_cnt), 32'd0);
        exp_q = '{8'h66};
        cmp_q("t6_launch", launched, exp_q);
        clear_logs();
        send_word(8'h99);
        wait_quiet();
        check("t6_fresh_done", 32'(done_cnt), 32'd1);
        exp_q = '{8'h99};
        cmp_q("t6_fresh_rx", rx_cap, exp_q);

        // Random bursts: words 1 and 2 are delivered, the rest overflow
        for (int it = 0; it < 24; it++) begin
            clear_logs();
            ack_dly = int'($urandom_range(1, 4));
            rel_dly = int'($urandom_range(1, 4));
            k = int'($urandom_range(1, 4));
            for (int j = 0; j < 4; j++) words[j] = 8'($urandom);
            for (int j = 0; j < k; j++) send_word(words[j]);
            wait_quiet();
            exp_q.delete();
            for (int j = 0; j < k && j < 2; j++) exp_q.push_back(words[j]);
            cmp_q($sformatf("r%0d_launch", it), launched, exp_q);
            cmp_q($sformatf("r%0d_rx", it), rx_cap, exp_q);
            check($sformatf("r%0d_done", it), 32'(done_cnt), 32'(exp_q.size()));
            check($sformatf("r%0d_ovf", it), 32'(ovf_cnt), 32'((k > 2) ? k - 2 : 0));
            check($sformatf("r%0d_tmo", it), 32'(to_cnt), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/handshake_event_tx.md
# handshake_event_tx

Source-side sender of a four-phase request/acknowledge crossing. Accepts single-cycle event strobes with a data word in the local `clk` domain, presents them as a level `req_out` plus stable `data_out` to a receiver in an unrelated clock domain, and waits for that receiver's asynchronous `ack_in`. It is the transmitting end of the team's asynchronous-capture receivers: it guarantees every event is held long enough, and stays stable long enough, to be captured safely on the far side. It includes a one-entry pending buffer and an acknowledge timeout.

## Interface
- `WIDTH`, 8, data word width.
- `SYNC_STAGES`, 2, flops in the `ack_in` synchronizer; legal range 2–4.
- `TIMEOUT`, 255, `clk` cycles to wait for `ack` high before aborting; 0 disables the timeout.

- `clk`  in  1  local clock; all logic on its rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `send`  in  1  single-cycle event strobe.
- `data_in`  in  WIDTH  payload, sampled when `send`=1.
- `ready`  out  1  high when `send` will be accepted, equal to !`pend_v`.
- `req_out`  out  1  registered request level to the remote domain.
- `data_out`  out  WIDTH  registered payload; stable whenever `req_out`=1.
- `ack_in`  in  1  remote acknowledge, asynchronous to `clk`.
- `done`  out  1  one-cycle pulse when a transfer completes normally.
- `overflow`  out  1  one-cycle pulse when an accepted-impossible `send` is dropped.
- `timeout_err`  out  1  one-cycle pulse when the acknowledge wait expires.

## Operation
- `ack_in` passes through a `SYNC_STAGES`-deep flop chain to produce `ack_s`. No other logic samples `ack_in` directly.
- The FSM has three states: IDLE, REQ_HI, REQ_LO.
- **IDLE:**
  - If `pend_v`=1, launch the pending word.
  - Otherwise, if `send`=1, launch `data_in`.
  - Launch means: load `data_out`, set `req_out`=1, clear the timer, and go to REQ_HI.
- **REQ_HI:**
  - Hold `req_out`=1 and keep `data_out` frozen.
  - If `ack_s`=1, drop `req_out` and go to REQ_LO.
  - If the timer reaches `TIMEOUT` (and `TIMEOUT` is not 0), drop `req_out`, pulse `timeout_err`, mark the transfer aborted, and go to REQ_LO.
- **REQ_LO:**
  - Hold `req_out`=0 and keep `data_out` frozen.
  - When `ack_s`=0, go to IDLE.
  - Pulse `done` on that transition only if the transfer was not aborted.
- **Pending buffer (one entry, `pend_v`, `pend_d`):**
  - In IDLE with `pend_v`=0, `send` launches directly and the buffer stays empty.
  - In IDLE with `pend_v`=1, the pending word launches. A `send` in the same cycle is written into the freed slot, so `pend_v` stays 1.
  - In REQ_HI or REQ_LO with `pend_v`=0, `send` is stored and `pend_v` is set.
  - In REQ_HI or REQ_LO with `pend_v`=1, `send` is dropped, `overflow` pulses, and `pend_d` is unchanged.
- The timer is `$clog2(TIMEOUT+1)` bits wide, counts only in REQ_HI, and saturates.
- `done`, `overflow` and `timeout_err` are registered pulses.
- **Reset (`clr`=1, at any time including mid-transfer):**
  - State goes to IDLE.
  - `req_out`, `data_out`, `pend_v`, `pend_d`, the timer, the aborted flag, every synchronizer flop, `done`, `overflow` and `timeout_err` all go to 0.
  - `ready` goes to 1.
  - A transfer in progress is abandoned without `done`.

## Timing
- Direct launch: `send` at edge n gives `req_out`=1 and valid `data_out` after edge n+1.
- `ack_in` rising is seen as `ack_s` after `SYNC_STAGES` edges; `req_out` falls on the following edge.
- Completion: `ack_in` falling is seen after `SYNC_STAGES` edges, then `done`=1 for exactly one cycle.
- Minimum transfer time is about 2·`SYNC_STAGES`+3 cycles plus remote latency.
- A pending word launches on the edge after IDLE is entered, so there is one IDLE cycle between transfers.
- `req_out` never rises while `ack_s`=1. This holds because REQ_LO always waits for `ack_s`=0.
- `data_out` changes only on the edge that launches a transfer. It never changes in REQ_HI or REQ_LO.

## Test plan
- **Reset.** Pulse `clr` with `SYNC_STAGES`=2.
  - Required: all outputs 0 except `ready`=1.
  - Then `send` with `data_in`=0xA5, and a bench receiver acks 3 cycles after `req_out` rises and releases 3 cycles after `req_out` falls.
  - Required: `req_out` high one cycle after `send`, `data_out`=0xA5 held throughout, exactly one `done` pulse, final state IDLE.
- **Back-to-back.** `send` 0x11, then `send` 0x22 while in REQ_HI.
  - Required: `ready` drops to 0.
  - Required: 0x22 launches one cycle after `done` for 0x11, giving two `done` pulses in order.
- **Overflow.** `send` 0x01, 0x02, 0x03 on consecutive cycles.
  - Required: `overflow` pulses once, on the 0x03 cycle.
  - Required: only 0x01 and 0x02 appear on `data_out`.
- **Simultaneous.** A new `send` 0x44 arrives in the same IDLE cycle that pending 0x33 launches.
  - Required: 0x33 transfers, then 0x44 transfers, with no `overflow`.
- **Timeout.** `TIMEOUT`=10 and `ack_in` held at 0.
  - Required: `timeout_err` pulses after 10 REQ_HI cycles and `req_out` falls.
  - Required: the FSM returns to IDLE with no `done`.
  - Then a normal transfer succeeds.
- **Reset mid-transfer.** Assert `clr` asynchronously while in REQ_HI.
  - Required: `req_out`=0 and `pend_v`=0 immediately, with no `done`.
  - Then a fresh transfer completes normally.
